inst_rom_port: RTL

Responder side of the instruction-fetch ROM handshake. It accepts word read requests (`r_enable_i`, `addr_i`) from the fetch stage and serves each miss by reading four bytes from a byte-wide, fixed-latency instruction memory. It assembles the bytes little-endian into one 32-bit instruction. A one-entry tagged word register lets repeated requests to the same address return combinationally with `busy_o` low, which lets the fetch stage's stall-on-busy logic work unchanged.

---
 rtl/inst_rom_port_pkg.sv | 23 ++
 rtl/inst_rom_port_if.sv | 27 ++
 rtl/inst_rom_port_mem_lat_pipe.sv | 29 ++
 rtl/inst_rom_port.sv | 118 +++++++++++
 4 files changed

// File: rtl/inst_rom_port_pkg.sv
// Shared definitions for the instruction ROM responder.
// Holds the FSM state encodings, the zero word, the number of bytes per
// instruction and a byte-insert helper for little-endian assembly.
package inst_rom_port_pkg;

    localparam logic [1:0]  RomIdle   = 2'd0;
    localparam logic [1:0]  RomFetch  = 2'd1;
    localparam logic [1:0]  RomDone   = 2'd2;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic [2:0]  InstBytes = 3'd4;

    // Returns w with byte lane idx replaced by b (lane 0 = bits [7:0]).
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/inst_rom_port_if.sv
// Fetch-stage <-> instruction ROM handshake.
//   r_enable_i : fetch request valid             (fetch -> rom)
//   addr_i     : instruction byte address        (fetch -> rom)
//   inv_i      : invalidate held word            (fetch -> rom)
//   data_o     : held instruction word           (rom -> fetch)
//   busy_o     : fetch in progress or miss       (rom -> fetch)
//   done_o     : one-cycle fetch-complete pulse  (rom -> fetch)
interface inst_rom_port_if;

    logic        r_enable_i;
    logic [31:0] addr_i;
    logic        inv_i;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output r_enable_i, addr_i, inv_i,
        input  data_o, busy_o, done_o
    );

    modport slave (
        input  r_enable_i, addr_i, inv_i,
        output data_o, busy_o, done_o
    );

endinterface

// File: rtl/inst_rom_port_mem_lat_pipe.sv
// In-flight read tracker: a MEM_LAT-deep valid shift register.
//   clk, rst  : clock, synchronous active-high clear
//   in_valid  : a read strobe is issued this cycle
//   out_valid : the data for a strobe issued MEM_LAT cycles ago is on the bus
module mem_lat_pipe #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid
);

    logic [MEM_LAT-1:0] vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign out_valid = vld[MEM_LAT-1];

endmodule

// File: rtl/inst_rom_port.sv
// Instruction ROM responder. Serves word fetches from a byte-wide,
// fixed-latency memory, assembling four bytes little-endian, and keeps one
// tagged word so repeated fetches of the same address hit with busy low.
//   clk, rst    : clock, synchronous active-high reset
//   fetch       : fetch-stage handshake (slave side)
//   mem_addr_o  : byte address to the instruction memory
//   mem_re_o    : read strobe, one per byte
//   mem_data_i  : read data, valid MEM_LAT cycles after its strobe
module inst_rom_port
    import inst_rom_port_pkg::*;
#(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_port_if.slave    fetch,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_data_i
);

    logic [1:0]        state;
    logic [ADDR_W-3:0] tag;
    logic              valid;
    logic [31:0]       word;
    logic [31:0]       asm_word;
    logic [ADDR_W-3:0] req_addr;
    logic [2:0]        issue_cnt;
    logic [2:0]        cap_cnt;
    logic              done_q;

    logic              hit;
    logic              issuing;
    logic              pipe_out;
    logic              capture;
    logic              complete;
    logic [31:0]       assembled;
    logic              unused_addr_bits;

    assign hit       = valid && (tag == fetch.addr_i[ADDR_W-1:2]);
    assign issuing   = (state == RomFetch) && (issue_cnt < InstBytes);
    assign capture   = pipe_out && (state == RomFetch);
    assign complete  = capture && (cap_cnt == InstBytes - 3'd1);
    assign assembled = put_byte(asm_word, cap_cnt[1:0], mem_data_i);

    assign unused_addr_bits = ^{fetch.addr_i[31:ADDR_W], fetch.addr_i[1:0]};

    assign mem_re_o   = issuing;
    assign mem_addr_o = issuing ? {req_addr, issue_cnt[1:0]} : '0;

    assign fetch.data_o = word;
    assign fetch.busy_o = (state != RomIdle) || (fetch.r_enable_i && !hit);
    assign fetch.done_o = done_q;

    mem_lat_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issuing),
        .out_valid (pipe_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RomIdle;
            tag       <= '0;
            valid     <= 1'b0;
            word      <= ZeroWord;
            asm_word  <= ZeroWord;
            req_addr  <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Invalidate first so a completing fetch on the same edge
            // overrides it below.
            if (fetch.inv_i) begin
                valid <= 1'b0;
            end
            case (state)
                RomIdle: begin
                    if (fetch.r_enable_i && !hit) begin
                        req_addr  <= fetch.addr_i[ADDR_W-1:2];
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        state     <= RomFetch;
                    end
                end
                RomFetch: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (capture) begin
                        asm_word <= assembled;
                        cap_cnt  <= cap_cnt + 3'd1;
                    end
                    if (complete) begin
                        word   <= assembled;
                        tag    <= req_addr;
                        valid  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= RomDone;
                    end
                end
                RomDone: begin
                    state <= RomIdle;
                end
                default: begin
                    state <= RomIdle;
                end
            endcase
        end
    end

endmodule
